epidemic_monitor: RTL
=====================

EPIDEMIC_MONITOR -- requirements
Module: epidemic_monitor

Interface
REQ-001 Parameter N_AGENTS, default 4, number of agent state bits observed (X*Y of the grid).
REQ-002 Parameter DEPTH, default 16, history FIFO entries, power of two, at least 2.
REQ-003 Parameter MAX_GEN, default 1000, generation limit, range 1 to 65535.
REQ-004 Local width CW = $clog2(N_AGENTS+1); FIFO occupancy width = $clog2(DEPTH)+1.
REQ-005 clk  in  1  single clock, all state updates on its rising edge.
REQ-006 Reset is asynchronous and active-low: rst_n  in  1  asynchronous active-low reset.
REQ-007 states  in  N_AGENTS  per-agent infected flags from the grid, 1 = infected.
REQ-008 loadState  in  1  the same load strobe driven into the grid; it starts a new run.
REQ-009 hist_data  out  CW+16  {gen[15:0], count[CW-1:0]} at the FIFO head.
REQ-010 hist_valid  out  1  FIFO is non-empty.
REQ-011 hist_ready  in  1  consumer accepts the head; a pop occurs when hist_valid and hist_ready are both high.
REQ-012 gen  out  16  generations sampled in the current run.
REQ-013 status  out  2  run outcome: 0 = none, 1 = EXTINCT, 2 = SATURATED, 3 = TIMEOUT.
REQ-014 done  out  1  high in the DONE state.
REQ-015 overflow  out  1  sticky flag: a sample was dropped because the FIFO was full.
REQ-016 peak_count  out  CW  maximum count seen in the current run.
REQ-017 peak_gen  out  16  generation at which peak_count was first reached.

Function
REQ-018 The FSM has four states: IDLE, ARM, RUN, DONE.
REQ-019 While loadState = 1, from any state:
- next state is ARM;
- the FIFO is flushed;
- gen, status, overflow, peak_count and peak_gen are cleared.
REQ-020 ARM goes to RUN on the first cycle with loadState = 0; that cycle is not sampled.
REQ-021 Every RUN cycle:
- count = popcount(states), computed combinationally at full CW width, with no truncation;
- {gen, count} is pushed to the FIFO;
- gen increments by 1.
REQ-022 A sample pushed at edge k is visible at hist_data no earlier than edge k+1 (one-cycle latency).
REQ-023 RUN to DONE, evaluated on the sampled count in this priority order:
- count == 0 gives EXTINCT;
- else count == N_AGENTS gives SATURATED;
- else gen == MAX_GEN-1 before the increment gives TIMEOUT.
The terminating sample is still pushed.
REQ-024 DONE holds status and gen until the next loadState; IDLE and DONE perform no pushes.
REQ-025 Push when full:
- with no pop in the same cycle, the sample is dropped, overflow is set, and gen still increments;
- with a simultaneous pop, both succeed.
REQ-026 Pop when empty is ignored; hist_data is don't-care while hist_valid = 0.
REQ-027 The FIFO read and write pointers wrap modulo DEPTH; the extra pointer bit distinguishes full from empty.
REQ-028 peak_count updates only when count > peak_count (strictly greater), so ties keep the earlier peak_gen.

Reset
REQ-029 rst_n = 0 asynchronously sets:
- FSM to IDLE;
- FIFO empty, hist_valid = 0;
- gen, status, done, overflow, peak_count and peak_gen to 0.
REQ-030 Reset asserted mid-RUN discards all history; after release the block stays in IDLE until loadState.

Configuration
REQ-031 Macro EPIDEMIC_MONITOR_PEAK_EN: when defined, peak tracking per REQ-028 is compiled in.
REQ-032 When undefined, no peak registers are built and peak_count and peak_gen are tied to 0.

Verification (N_AGENTS=4, DEPTH=16, MAX_GEN=1000)
REQ-033 Extinction:
- stimulus: loadState pulse, then states 0011, 0001, 0000, with hist_ready = 1;
- response: pops {0,2}, {1,1}, {2,0}; status = 1; done = 1; gen = 3.
REQ-034 Saturation:
- stimulus: states 0001, 0111, 1111;
- response: status = 2 after 3 samples; peak_count = 4, peak_gen = 2 when the macro is defined, 0 and 0 when not.
REQ-035 Overflow:
- stimulus: hist_ready = 0, states held at 0101 for 20 RUN cycles;
- response: 16 entries held, overflow = 1, gen = 20, and the head is {0,2}.
REQ-036 Timeout:
- stimulus: MAX_GEN = 3, states held at 0110;
- response: 3 pushes, then status = 3 and gen = 3.
REQ-037 Async reset mid-RUN:
- stimulus: rst_n low for half a cycle after 5 samples;
- response: hist_valid = 0, gen = 0 and status = 0 immediately; no pushes until the next loadState.
REQ-038 Full with simultaneous pop:
- stimulus: FIFO full, with push and pop in the same cycle;
- response: occupancy stays 16, overflow stays 0, and the pointer wraps correctly.

Source files
------------

// File: rtl/epidemic_monitor.sv
// Epidemic monitor: samples grid infection counts into a history FIFO.
// Optional peak tracking is enabled by defining EPIDEMIC_MONITOR_PEAK_EN.
module epidemic_monitor #(
   parameter int N_AGENTS = 4,
   parameter int DEPTH    = 16,
   parameter int MAX_GEN  = 1000,
   localparam int CW      = $clog2(N_AGENTS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_AGENTS-1:0] states,
   input  logic                loadState,
   output logic [CW+15:0]      hist_data,
   output logic                hist_valid,
   input  logic                hist_ready,
   output logic [15:0]         gen,
   output logic [1:0]          status,
   output logic                done,
   output logic                overflow,
   output logic [CW-1:0]       peak_count,
   output logic [15:0]         peak_gen
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = CW + 16;
   localparam logic [CW-1:0] CNT_FULL = CW'(N_AGENTS);
   localparam logic [15:0] GEN_LAST = 16'(MAX_GEN - 1);

   localparam logic [1:0] ST_NONE = 2'd0;
   localparam logic [1:0] ST_EXT  = 2'd1;
   localparam logic [1:0] ST_SAT  = 2'd2;
   localparam logic [1:0] ST_TMO  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARM,
      S_RUN,
      S_DONE
   } state_t;

   state_t        state_q;
   logic [15:0]   gen_q;
   logic [1:0]    status_q;
   logic          done_q;
   logic          ovf_q;
   logic [CW-1:0] count_d;
   logic [AW:0]   wptr_q;
   logic [AW:0]   rptr_q;
   logic [DW-1:0] mem_q [DEPTH];
   logic          empty;
   logic          full;
   logic          push;
   logic          pop;
   logic          wr_en;

   // Population count of infected agents, kept at full counter width
   always_comb begin
      count_d = '0;
      for (int i = 0; i < N_AGENTS; i++) begin
         count_d = count_d + CW'(states[i]);
      end
   end

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign push  = (state_q == S_RUN) && !loadState;
   assign pop   = !empty && hist_ready;
   assign wr_en = push && (!full || pop);

   assign hist_valid = !empty;
   assign hist_data  = mem_q[rptr_q[AW-1:0]];
   assign gen        = gen_q;
   assign status     = status_q;
   assign done       = done_q;
   assign overflow   = ovf_q;

   // FIFO pointers; a load strobe flushes the history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else if (loadState) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (wr_en) wptr_q <= wptr_q + (AW+1)'(1);
         if (pop)   rptr_q <= rptr_q + (AW+1)'(1);
      end
   end

   // History storage, written with the sample of the current generation
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wptr_q[AW-1:0]] <= {gen_q, count_d};
   end

   // Run control FSM with registered generation, outcome and overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         gen_q    <= '0;
         status_q <= ST_NONE;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (loadState) begin
         state_q  <= S_ARM;
         gen_q    <= '0;
         status_q <= ST_NONE;
         done_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: state_q <= S_IDLE;
            S_ARM:  state_q <= S_RUN;
            S_RUN: begin
               gen_q <= gen_q + 16'd1;
               if (full && !pop) ovf_q <= 1'b1;
               if (count_d == '0) begin
                  state_q  <= S_DONE;
                  status_q <= ST_EXT;
                  done_q   <= 1'b1;
               end else if (count_d == CNT_FULL) begin
                  state_q  <= S_DONE;
                  status_q <= ST_SAT;
                  done_q   <= 1'b1;
               end else if (gen_q == GEN_LAST) begin
                  state_q  <= S_DONE;
                  status_q <= ST_TMO;
                  done_q   <= 1'b1;
               end
            end
            S_DONE: state_q <= S_DONE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef EPIDEMIC_MONITOR_PEAK_EN
   logic [CW-1:0] peak_cnt_q;
   logic [15:0]   peak_gen_q;

   // Peak tracking; ties keep the earliest generation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         peak_cnt_q <= '0;
         peak_gen_q <= '0;
      end else if (loadState) begin
         peak_cnt_q <= '0;
         peak_gen_q <= '0;
      end else if (push && (count_d > peak_cnt_q)) begin
         peak_cnt_q <= count_d;
         peak_gen_q <= gen_q;
      end
   end

   assign peak_count = peak_cnt_q;
   assign peak_gen   = peak_gen_q;
`else
   assign peak_count = '0;
   assign peak_gen   = '0;
`endif

endmodule
